branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch decision logic.
- Does its own operand comparison for all six RV32 conditional branches, signed and unsigned.
- Keeps a 2-bit saturating branch history table (BHT) that fetch queries for a prediction.
- Registers each resolution one cycle later as taken / mispredict / redirect-PC for the pipeline's flush logic.

Parameters:
- XLEN, 32, operand width in bits.
- PC_W, 32, program counter width in bits.
- BHT_DEPTH, 16, number of BHT entries; must be a power of 2 and at least 2. IDX_W = log2(BHT_DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- lookup_pc  in  PC_W  fetch PC to predict
- lookup_taken  out  1  prediction for lookup_pc; combinational read of the table
- br_valid  in  1  branch present this cycle
- br_func3  in  3  RISC-V funct3
- br_op_a  in  XLEN  rs1 value
- br_op_b  in  XLEN  rs2 value
- br_pc  in  PC_W  branch PC
- br_target  in  PC_W  taken target
- br_pred_taken  in  1  prediction fetch used for this branch
- flush  in  1  kill the in-flight branch
- res_valid  out  1  resolution valid
- res_taken  out  1  actual outcome
- res_mispredict  out  1  res_taken differs from br_pred_taken
- res_redirect_pc  out  PC_W  correct next PC
- res_illegal  out  1  unsupported funct3

Behaviour:
- Reset (rst_n low, asynchronous):
  - All res_* outputs are 0; res_redirect_pc is 0.
  - Every BHT entry is 2'b01 (weakly not-taken), so lookup_taken reads 0.
- funct3 decode:
  - 000 BEQ: a==b. 001 BNE: a!=b.
  - 100 BLT and 101 BGE: signed compare.
  - 110 BLTU and 111 BGEU: unsigned compare.
  - 010 and 011: illegal.
  - All compares run at full XLEN.
- Latency is 1:
  - br_* inputs sampled at edge k appear on res_* during cycle k+1.
  - res_valid is a one-cycle pulse per accepted branch. Back-to-back branches every cycle are supported.
- res_redirect_pc = taken ? br_target : br_pc + 4, computed modulo 2^PC_W (wraps at the top of the address space).
- Illegal funct3:
  - res_valid=1, res_illegal=1, res_taken=0, res_mispredict=0, res_redirect_pc=br_pc+4.
  - No BHT update.
- BHT index is pc[IDX_W+1:2]; bits [1:0] are ignored.
- BHT update:
  - Happens at the same edge k that captures a valid, legal, non-flushed branch.
  - Taken increments the entry, saturating at 11. Not-taken decrements it, saturating at 00.
- Prediction: lookup_taken = entry[1].
- Lookup and update to the same index in the same cycle: lookup returns the pre-update value, with no bypass. The new value is visible from cycle k+1.
- flush:
  - flush=1 at edge k: res_valid=0 in cycle k+1 and no BHT update, even if br_valid=1 in that cycle.
  - A result already on res_* in cycle k is unaffected.
- Reset asserted mid-operation: the in-flight result is discarded and the table reinitialises. The first post-reset lookup predicts not-taken.
- br_valid=0: res_valid=0 next cycle. The other res_* fields hold their previous values and are don't-care.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches (out, 32) and stat_mispredicts (out, 32).
  - Each increments when res_valid (or res_valid&res_mispredict) is 1 and res_illegal is 0.
  - Both saturate at 32'hFFFF_FFFF and are reset to 0 by rst_n.
- Undefined: the ports and counters are absent; the functional behaviour is identical.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - 2-bit counter state constants SNT/WNT/WT/ST, with reset value WNT.
- One sub-module, bht_2bit_table:
  - Parameter BHT_DEPTH.
  - Async reset, one combinational read port, one write/update port (index, taken, enable).
- The top level holds the comparator, the result register, and the stats logic.

Test Plan:
1. Reset, then lookup_pc=0x100 → lookup_taken=0. BEQ a=5 b=5 pc=0x100 target=0x80 pred=0 → next cycle res_valid=1, taken=1, mispredict=1, redirect=0x80.
2. BLT a=0xFFFFFFFF b=1 → taken=1; BLTU with the same operands → taken=0. BGE a=b=7 → taken; BGEU 0<0x80000000 → not taken.
3. Four taken branches at pc=0x40 on consecutive cycles → lookup_taken for 0x40 goes 0,1,1,1, and the entry saturates at 11. Then three not-taken branches → entry 00 and lookup_taken=0.
4. br_valid=1 with flush=1 at pc=0x40 → res_valid=0 next cycle and the BHT entry is unchanged (lookup_taken is the same before and after).
5. funct3=010 → res_illegal=1, taken=0, redirect=pc+4, no BHT change. Branch at pc=0xFFFFFFFC not taken → redirect=0x0.
6. BRANCH_STATS_EN defined: 10 legal branches with 3 mispredicts plus 1 illegal → stat_branches=10, stat_mispredicts=3. Assert rst_n mid-stream → both 0 and res_valid=0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: RV32 branch funct3 codes and
// 2-bit saturating counter states, plus the counter update helper.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam logic [1:0] BHT_RESET = WNT;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit_table.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for fetch prediction, one update port written at the resolving edge.
module bht_2bit_table
  import branch_pkg::*;
#(
  parameter int BHT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(BHT_DEPTH)-1:0] rd_idx,
  output logic                         rd_taken,
  input  logic                         upd_en,
  input  logic [$clog2(BHT_DEPTH)-1:0] upd_idx,
  input  logic                         upd_taken
);

  logic [1:0] table_q [BHT_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) table_q[i] <= BHT_RESET;
    end else if (upd_en) begin
      table_q[upd_idx] <= sat_update(table_q[upd_idx], upd_taken);
    end
  end

  // Read sees the pre-update value in the update cycle; no bypass by design.
  assign rd_taken = table_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32 conditional branches one cycle after issue and keeps the BHT
// used by fetch. Optional counters enabled with macro BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_taken,
  input  logic            br_valid,
  input  logic [2:0]      br_func3,
  input  logic [XLEN-1:0] br_op_a,
  input  logic [XLEN-1:0] br_op_b,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_target,
  input  logic            br_pred_taken,
  input  logic            flush,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [PC_W-1:0] res_redirect_pc,
  output logic            res_illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             cmp_taken;
  logic             cmp_illegal;
  logic             accept;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] br_idx;
  logic             unused_pc_bits;

  always_comb begin
    cmp_taken   = 1'b0;
    cmp_illegal = 1'b0;
    unique case (br_func3)
      BEQ:     cmp_taken = (br_op_a == br_op_b);
      BNE:     cmp_taken = (br_op_a != br_op_b);
      BLT:     cmp_taken = ($signed(br_op_a) <  $signed(br_op_b));
      BGE:     cmp_taken = ($signed(br_op_a) >= $signed(br_op_b));
      BLTU:    cmp_taken = (br_op_a <  br_op_b);
      BGEU:    cmp_taken = (br_op_a >= br_op_b);
      default: cmp_illegal = 1'b1;
    endcase
  end

  assign accept     = br_valid && !flush;
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign br_idx     = br_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                            br_pc[PC_W-1:IDX_W+2]};

  bht_2bit_table #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lookup_idx),
    .rd_taken  (lookup_taken),
    .upd_en    (accept && !cmp_illegal),
    .upd_idx   (br_idx),
    .upd_taken (cmp_taken)
  );

  // Payload fields only load on an accepted branch; they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid       <= 1'b0;
      res_taken       <= 1'b0;
      res_mispredict  <= 1'b0;
      res_redirect_pc <= '0;
      res_illegal     <= 1'b0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        res_taken       <= cmp_taken;
        res_mispredict  <= !cmp_illegal && (cmp_taken != br_pred_taken);
        res_redirect_pc <= cmp_taken ? br_target : br_pc + PC_W'(4);
        res_illegal     <= cmp_illegal;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (res_valid && !res_illegal) begin
      if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (res_mispredict && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
